dfx_slot_sequencer: RTL and testbench

- Walks the slot table (bank1), one slot at a time, from index 0 to a programmed end count.
- For each slot it issues an MM2S (source) and an S2MM (destination) DMA command, then waits for both to complete.
- On completion it writes the slot's status and its cycle-count profile back into the table.
- Controlled by the bank0 control and endCnt registers; reports busy, done and error back to bank0 status.

---
 rtl/dfx_slot_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_dfx_slot_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfx_slot_sequencer.sv
// Slot-table sequencer: for each slot from 0 to end_cnt, issues MM2S/S2MM DMA
// commands, waits for both to complete, and writes status and profile back.
//
// state | meaning
// IDLE  | waiting for a start strobe
// LOAD  | latch slot fields, mark slot running
// ISSUE | present command valids until both are accepted or skipped
// WAIT  | collect completion pulses from both channels
// WB    | write done status and profile, then advance or finish
// FIN   | run complete, drop busy and raise done
// ERR   | write error status, raise seq_err
module dfx_slot_sequencer #(
  parameter int IDX_W  = 2,
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 26,
  parameter int STAT_W = 2,
  parameter int PROF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        ctrl_data,
  input  logic              ctrl_set,
  input  logic [IDX_W-1:0]  end_cnt,
  output logic [IDX_W-1:0]  tbl_rd_index,
  input  logic [ADDR_W-1:0] tbl_src_addr,
  input  logic [ADDR_W-1:0] tbl_des_addr,
  input  logic [SIZE_W-1:0] tbl_src_size,
  input  logic [SIZE_W-1:0] tbl_des_size,
  output logic [ADDR_W-1:0] mm2s_cmd_addr,
  output logic [ADDR_W-1:0] s2mm_cmd_addr,
  output logic [SIZE_W-1:0] mm2s_cmd_size,
  output logic [SIZE_W-1:0] s2mm_cmd_size,
  output logic              mm2s_cmd_valid,
  output logic              s2mm_cmd_valid,
  input  logic              mm2s_cmd_ready,
  input  logic              s2mm_cmd_ready,
  input  logic              mm2s_done,
  input  logic              s2mm_done,
  input  logic              mm2s_err,
  input  logic              s2mm_err,
  output logic [IDX_W-1:0]  wb_index,
  output logic [STAT_W-1:0] wb_status,
  output logic              wb_set_status,
  output logic [PROF_W-1:0] wb_profile,
  output logic              wb_set_profile,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [IDX_W-1:0]  cur_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_WB, S_FIN, S_ERR
  } state_t;

  localparam logic [STAT_W-1:0] ST_RUN  = STAT_W'(1);
  localparam logic [STAT_W-1:0] ST_DONE = STAT_W'(2);
  localparam logic [STAT_W-1:0] ST_ERR  = STAT_W'(3);

  state_t            state_q;
  logic [IDX_W-1:0]  cur_q, end_q;
  logic              stop_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] mm_addr_q, s2_addr_q;
  logic [SIZE_W-1:0] mm_size_q, s2_size_q;
  logic              mm_vld_q, s2_vld_q;
  logic              mm_acc_q, s2_acc_q, mm_dn_q, s2_dn_q;
  logic [PROF_W-1:0] prof_q;
  logic [STAT_W-1:0] wb_status_q;
  logic              wb_set_status_q, wb_set_profile_q;
  logic [PROF_W-1:0] wb_profile_q;

  logic              ctrl_start, ctrl_stop, ctrl_clr;
  logic              mm_acc_d, s2_acc_d, mm_dn_d, s2_dn_d, any_err;
  logic [PROF_W-1:0] prof_d;
  logic              unused_ctrl;

  assign ctrl_start  = ctrl_set & ctrl_data[0];
  assign ctrl_stop   = ctrl_set & ctrl_data[1];
  assign ctrl_clr    = ctrl_set & ctrl_data[2];
  assign unused_ctrl = ctrl_data[3];

  assign mm_acc_d = mm_acc_q | (mm_vld_q & mm2s_cmd_ready);
  assign s2_acc_d = s2_acc_q | (s2_vld_q & s2mm_cmd_ready);
  assign mm_dn_d  = mm_dn_q | mm2s_done;
  assign s2_dn_d  = s2_dn_q | s2mm_done;
  assign any_err  = mm2s_err | s2mm_err;
  // Profile saturates rather than wrapping on very long transfers.
  assign prof_d   = (&prof_q) ? prof_q : prof_q + PROF_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      cur_q            <= '0;
      end_q            <= '0;
      stop_q           <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      mm_addr_q        <= '0;
      s2_addr_q        <= '0;
      mm_size_q        <= '0;
      s2_size_q        <= '0;
      mm_vld_q         <= 1'b0;
      s2_vld_q         <= 1'b0;
      mm_acc_q         <= 1'b0;
      s2_acc_q         <= 1'b0;
      mm_dn_q          <= 1'b0;
      s2_dn_q          <= 1'b0;
      prof_q           <= '0;
      wb_status_q      <= '0;
      wb_set_status_q  <= 1'b0;
      wb_set_profile_q <= 1'b0;
      wb_profile_q     <= '0;
    end else begin
      wb_set_status_q  <= 1'b0;
      wb_set_profile_q <= 1'b0;
      if (ctrl_stop && busy_q) stop_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (ctrl_clr) err_q <= 1'b0;
          // Clear is applied ahead of start within the same strobe.
          if (ctrl_start && (!err_q || ctrl_clr)) begin
            cur_q           <= '0;
            end_q           <= end_cnt;
            done_q          <= 1'b0;
            busy_q          <= 1'b1;
            wb_status_q     <= ST_RUN;
            wb_set_status_q <= 1'b1;
            state_q         <= S_LOAD;
          end
        end
        S_LOAD: begin
          mm_addr_q <= tbl_src_addr;
          mm_size_q <= tbl_src_size;
          s2_addr_q <= tbl_des_addr;
          s2_size_q <= tbl_des_size;
          mm_vld_q  <= (tbl_src_size != '0);
          s2_vld_q  <= (tbl_des_size != '0);
          mm_acc_q  <= (tbl_src_size == '0);
          s2_acc_q  <= (tbl_des_size == '0);
          mm_dn_q   <= (tbl_src_size == '0);
          s2_dn_q   <= (tbl_des_size == '0);
          prof_q    <= '0;
          state_q   <= S_ISSUE;
        end
        S_ISSUE, S_WAIT: begin
          if (any_err) begin
            mm_vld_q        <= 1'b0;
            s2_vld_q        <= 1'b0;
            wb_status_q     <= ST_ERR;
            wb_set_status_q <= 1'b1;
            err_q           <= 1'b1;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            state_q         <= S_ERR;
          end else begin
            mm_vld_q <= mm_vld_q & ~mm2s_cmd_ready;
            s2_vld_q <= s2_vld_q & ~s2mm_cmd_ready;
            mm_acc_q <= mm_acc_d;
            s2_acc_q <= s2_acc_d;
            mm_dn_q  <= mm_dn_d;
            s2_dn_q  <= s2_dn_d;
            prof_q   <= prof_d;
            if (state_q == S_ISSUE) begin
              if (mm_acc_d && s2_acc_d) state_q <= S_WAIT;
            end else if (mm_dn_d && s2_dn_d) begin
              wb_status_q      <= ST_DONE;
              wb_set_status_q  <= 1'b1;
              wb_profile_q     <= prof_d;
              wb_set_profile_q <= 1'b1;
              state_q          <= S_WB;
            end
          end
        end
        S_WB: begin
          if ((cur_q == end_q) || stop_q || ctrl_stop) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            cur_q           <= cur_q + IDX_W'(1);
            wb_status_q     <= ST_RUN;
            wb_set_status_q <= 1'b1;
            state_q         <= S_LOAD;
          end
        end
        S_FIN: begin
          stop_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          stop_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tbl_rd_index   = cur_q;
  assign cur_cnt        = cur_q;
  assign wb_index       = cur_q;
  assign mm2s_cmd_addr  = mm_addr_q;
  assign mm2s_cmd_size  = mm_size_q;
  assign mm2s_cmd_valid = mm_vld_q;
  assign s2mm_cmd_addr  = s2_addr_q;
  assign s2mm_cmd_size  = s2_size_q;
  assign s2mm_cmd_valid = s2_vld_q;
  assign wb_status      = wb_status_q;
  assign wb_set_status  = wb_set_status_q;
  assign wb_profile     = wb_profile_q;
  assign wb_set_profile = wb_set_profile_q;
  assign seq_busy       = busy_q;
  assign seq_done       = done_q;
  assign seq_err        = err_q;

endmodule

// File: tb/tb_dfx_slot_sequencer.sv
// Directed bench for dfx_slot_sequencer: slot-table and DMA models driven at
// negedge, scenario table with hand-computed write-back results.
module tb_dfx_slot_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctrl_data;
  logic        ctrl_set;
  logic [1:0]  end_cnt;
  logic [1:0]  tbl_rd_index;
  logic [31:0] tbl_src_addr, tbl_des_addr;
  logic [25:0] tbl_src_size, tbl_des_size;
  logic [31:0] mm2s_cmd_addr, s2mm_cmd_addr;
  logic [25:0] mm2s_cmd_size, s2mm_cmd_size;
  logic        mm2s_cmd_valid, s2mm_cmd_valid;
  logic        mm2s_cmd_ready, s2mm_cmd_ready;
  logic        mm2s_done, s2mm_done, mm2s_err, s2mm_err;
  logic [1:0]  wb_index;
  logic [1:0]  wb_status;
  logic        wb_set_status;
  logic [31:0] wb_profile;
  logic        wb_set_profile;
  logic        seq_busy, seq_done, seq_err;
  logic [1:0]  cur_cnt;

  dfx_slot_sequencer dut (
    .clk(clk), .reset(reset), .ctrl_data(ctrl_data), .ctrl_set(ctrl_set),
    .end_cnt(end_cnt), .tbl_rd_index(tbl_rd_index),
    .tbl_src_addr(tbl_src_addr), .tbl_des_addr(tbl_des_addr),
    .tbl_src_size(tbl_src_size), .tbl_des_size(tbl_des_size),
    .mm2s_cmd_addr(mm2s_cmd_addr), .s2mm_cmd_addr(s2mm_cmd_addr),
    .mm2s_cmd_size(mm2s_cmd_size), .s2mm_cmd_size(s2mm_cmd_size),
    .mm2s_cmd_valid(mm2s_cmd_valid), .s2mm_cmd_valid(s2mm_cmd_valid),
    .mm2s_cmd_ready(mm2s_cmd_ready), .s2mm_cmd_ready(s2mm_cmd_ready),
    .mm2s_done(mm2s_done), .s2mm_done(s2mm_done),
    .mm2s_err(mm2s_err), .s2mm_err(s2mm_err),
    .wb_index(wb_index), .wb_status(wb_status), .wb_set_status(wb_set_status),
    .wb_profile(wb_profile), .wb_set_profile(wb_set_profile),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
    .cur_cnt(cur_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] src_addr_m [4];
  logic [31:0] des_addr_m [4];
  logic [25:0] src_size_m [4];
  logic [25:0] des_size_m [4];

  assign tbl_src_addr = src_addr_m[tbl_rd_index];
  assign tbl_des_addr = des_addr_m[tbl_rd_index];
  assign tbl_src_size = src_size_m[tbl_rd_index];
  assign tbl_des_size = des_size_m[tbl_rd_index];

  int stall_cfg = 0;
  int err_slot  = -1;
  int clr_gen   = 0;

  // Recorded write-backs: hist shifts in each status written to a slot.
  logic [7:0]  hist   [4];
  logic [31:0] prof_m [4];
  int          mm_v, s2_v, addr_bad;

  int n_vec = 0;
  int n_err = 0;

  // DMA model and write-back recorder, both evaluated at negedge.
  initial begin
    int  dc [2];
    int  sl [2];
    bit  armed [2];
    int  clr_seen;
    bit  v, rdy, pulse;
    clr_seen = 0;
    for (int c = 0; c < 2; c++) begin dc[c] = 0; sl[c] = 0; armed[c] = 0; end
    for (int s = 0; s < 4; s++) begin hist[s] = '0; prof_m[s] = '0; end
    mm_v = 0; s2_v = 0; addr_bad = 0;
    mm2s_cmd_ready = 0; s2mm_cmd_ready = 0;
    mm2s_done = 0; s2mm_done = 0; mm2s_err = 0; s2mm_err = 0;
    forever begin
      @(negedge clk);
      if (clr_seen != clr_gen) begin
        clr_seen = clr_gen;
        for (int s = 0; s < 4; s++) begin hist[s] = '0; prof_m[s] = '0; end
        mm_v = 0; s2_v = 0; addr_bad = 0;
      end
      if (wb_set_status)  hist[wb_index] = {hist[wb_index][5:0], wb_status};
      if (wb_set_profile) prof_m[wb_index] = wb_profile;
      if (tbl_rd_index != cur_cnt || wb_index != cur_cnt) addr_bad++;
      if (mm2s_cmd_valid) begin
        mm_v++;
        if (mm2s_cmd_addr != src_addr_m[cur_cnt] || mm2s_cmd_size != src_size_m[cur_cnt]) addr_bad++;
      end
      if (s2mm_cmd_valid) begin
        s2_v++;
        if (s2mm_cmd_addr != des_addr_m[cur_cnt] || s2mm_cmd_size != des_size_m[cur_cnt]) addr_bad++;
      end
      mm2s_done = 0; s2mm_done = 0; mm2s_err = 0; s2mm_err = 0;
      if (!reset) begin
        for (int c = 0; c < 2; c++) begin dc[c] = 0; sl[c] = 0; armed[c] = 0; end
        mm2s_cmd_ready = 0; s2mm_cmd_ready = 0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          v = (c == 0) ? mm2s_cmd_valid : s2mm_cmd_valid;
          rdy = 0; pulse = 0;
          if (dc[c] > 0) begin
            dc[c]--;
            if (dc[c] == 0) pulse = 1;
          end
          if (!v) armed[c] = 0;
          else begin
            if (!armed[c]) begin armed[c] = 1; sl[c] = stall_cfg; end
            if (sl[c] > 0) sl[c]--;
            else begin rdy = 1; dc[c] = 5; end
          end
          if (c == 0) begin
            mm2s_cmd_ready = rdy;
            mm2s_done = pulse;
          end else begin
            s2mm_cmd_ready = rdy;
            if (pulse) begin
              if (err_slot == int'(cur_cnt)) s2mm_err = 1;
              else s2mm_done = 1;
            end
          end
        end
      end
    end
  end

  typedef struct packed {
    logic [1:0]   end_v;
    bit           zero_src1;
    bit           stop0;
    bit           restrobe;
    bit           clr;
    int           stall;
    int           err_slot;
    logic [31:0]  exp_hist;   // {slot3, slot2, slot1, slot0}
    logic [127:0] exp_prof;   // {slot3, slot2, slot1, slot0}
    bit           exp_done;
    bit           exp_err;
    int           exp_mm_v;
    int           exp_s2_v;
  } scn_t;

  function automatic scn_t mk(input logic [1:0] e, input bit z, input bit st,
                              input bit rs, input bit cl, input int stall,
                              input int es, input logic [31:0] h,
                              input logic [127:0] p, input bit d, input bit er,
                              input int mv, input int sv);
    scn_t s;
    s.end_v = e; s.zero_src1 = z; s.stop0 = st; s.restrobe = rs; s.clr = cl;
    s.stall = stall; s.err_slot = es; s.exp_hist = h; s.exp_prof = p;
    s.exp_done = d; s.exp_err = er; s.exp_mm_v = mv; s.exp_s2_v = sv;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [3:0] d);
    ctrl_data = d;
    ctrl_set  = 1'b1;
    @(negedge clk);
    ctrl_set  = 1'b0;
    ctrl_data = 4'h0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, {51'd0, mm2s_cmd_valid, s2mm_cmd_valid, wb_set_status,
          wb_set_profile, seq_busy, seq_done, seq_err, cur_cnt, wb_index, wb_status}, 64'd0);
    check({tag, "_rdidx"}, {62'd0, tbl_rd_index}, 64'd0);
    check({tag, "_prof"}, {32'd0, wb_profile}, 64'd0);
    check({tag, "_addr"}, {mm2s_cmd_addr, s2mm_cmd_addr}, 64'd0);
    check({tag, "_size"}, {12'd0, mm2s_cmd_size, s2mm_cmd_size}, 64'd0);
  endtask

  task automatic run_scn(input string tag, input scn_t s);
    int cyc;
    src_size_m[1] = s.zero_src1 ? 26'd0 : 26'd128;
    stall_cfg = s.stall;
    err_slot  = s.err_slot;
    clr_gen++;
    @(negedge clk);
    end_cnt = s.end_v;
    strobe(s.clr ? 4'b0101 : 4'b0001);
    end_cnt = ~s.end_v;
    if (s.stop0) begin
      repeat (4) @(negedge clk);
      strobe(4'b0010);
    end
    if (s.restrobe) begin
      repeat (10) @(negedge clk);
      end_cnt = 2'd0;
      strobe(4'b0001);
    end
    cyc = 0;
    while (cyc < 500 && !(seq_done || seq_err)) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_finished"}, {63'd0, seq_done | seq_err}, 64'd1);
    check({tag, "_done"}, {63'd0, seq_done}, {63'd0, s.exp_done});
    check({tag, "_err"}, {63'd0, seq_err}, {63'd0, s.exp_err});
    check({tag, "_busy"}, {63'd0, seq_busy}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_status_slot%0d", tag, i), {56'd0, hist[i]}, {56'd0, s.exp_hist[i*8 +: 8]});
      check($sformatf("%s_profile_slot%0d", tag, i), {32'd0, prof_m[i]}, {32'd0, s.exp_prof[i*32 +: 32]});
    end
    check({tag, "_mm2s_valid_cycles"}, 64'(mm_v), 64'(s.exp_mm_v));
    check({tag, "_s2mm_valid_cycles"}, 64'(s2_v), 64'(s.exp_s2_v));
    check({tag, "_cmd_fields"}, 64'(addr_bad), 64'd0);
  endtask

  scn_t tv [7];

  initial begin
    tv[0] = mk(2'd2, 0, 0, 0, 0, 0, -1, 32'h00060606, {32'd0, 32'd6, 32'd6, 32'd6}, 1, 0, 3, 3);
    tv[1] = mk(2'd2, 1, 0, 0, 0, 0, -1, 32'h00060606, {32'd0, 32'd6, 32'd6, 32'd6}, 1, 0, 2, 3);
    tv[2] = mk(2'd3, 0, 1, 0, 0, 0, -1, 32'h00000006, {32'd0, 32'd0, 32'd0, 32'd6}, 1, 0, 1, 1);
    tv[3] = mk(2'd0, 0, 0, 0, 0, 4, -1, 32'h00000006, {32'd0, 32'd0, 32'd0, 32'd10}, 1, 0, 5, 5);
    tv[4] = mk(2'd3, 0, 0, 1, 0, 0, -1, 32'h06060606, {32'd6, 32'd6, 32'd6, 32'd6}, 1, 0, 4, 4);
    tv[5] = mk(2'd3, 0, 0, 0, 0, 0,  1, 32'h00000706, {32'd0, 32'd0, 32'd0, 32'd6}, 0, 1, 2, 2);
    tv[6] = mk(2'd0, 0, 0, 0, 1, 0, -1, 32'h00000006, {32'd0, 32'd0, 32'd0, 32'd6}, 1, 0, 1, 1);

    for (int i = 0; i < 4; i++) begin
      src_addr_m[i] = 32'h1000_0000 + 32'(i) * 32'h100;
      des_addr_m[i] = 32'h2000_0000 + 32'(i) * 32'h100;
      src_size_m[i] = 26'(64 * (i + 1));
      des_size_m[i] = 26'(32 * (i + 1));
    end

    reset = 1'b0; ctrl_data = 4'h0; ctrl_set = 1'b0; end_cnt = 2'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (tv[i].clr) begin
        // A plain start while the error flag is set must be ignored.
        clr_gen++;
        @(negedge clk);
        end_cnt = 2'd0;
        strobe(4'b0001);
        repeat (6) @(negedge clk);
        check("start_ignored_busy", {63'd0, seq_busy}, 64'd0);
        check("start_ignored_err", {63'd0, seq_err}, 64'd1);
        check("start_ignored_writes", {32'd0, hist[3], hist[2], hist[1], hist[0]}, 64'd0);
      end
      run_scn($sformatf("vec%0d", i), tv[i]);
    end

    // Reset in the middle of a slot's WAIT phase.
    stall_cfg = 0; err_slot = -1;
    end_cnt = 2'd3;
    strobe(4'b0001);
    repeat (4) @(negedge clk);
    check("midrst_was_busy", {63'd0, seq_busy}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    clr_gen++;
    repeat (8) @(negedge clk);
    check("midrst_no_writeback", {32'd0, hist[3], hist[2], hist[1], hist[0]}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("postrst");
    run_scn("after_rst", mk(2'd1, 0, 0, 0, 0, 0, -1, 32'h00000606,
            {32'd0, 32'd0, 32'd6, 32'd6}, 1, 0, 2, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
